astable_555_vco_bank: RTL

- Parametrised, multi-channel successor to the single-channel 555 astable VCO.
- Time-multiplexed capacitor-voltage model: each channel integrates its timing capacitor toward VCC or ground and compares it against v_control and v_control/2, as a real 555 does.
- Adds a per-channel 555 reset pin, a realistic first-cycle period and one shared multiplier for all channels.
- Feeds the audio mixer like the existing VCO.

---
 rtl/astable_555_vco_bank.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/astable_555_vco_bank.sv
// astable_555_vco_bank
// Multi-channel 555 astable oscillator bank. Each channel models its timing
// capacitor as a Q16.16 voltage. The capacitor charges toward VCC and
// discharges toward ground. The thresholds are v_control and v_control/2.
// Channels are updated one per clock, round-robin, through one shared
// multiplier.
module astable_555_vco_bank #(
  parameter int CLOCK_RATE  = 50000000,
  parameter int STEP_RATE   = 1000000,
  parameter int CHANNELS    = 4,
  parameter int K_SHIFT     = 24,
  parameter int K_CHARGE    = 6870,
  parameter int K_DISCHARGE = 18830,
  parameter int OUT_HIGH    = 32767
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    audio_clk_en,
  input  logic [16*CHANNELS-1:0]  v_control,
  input  logic [CHANNELS-1:0]     pin_reset_n,
  output logic [16*CHANNELS-1:0]  out,
  output logic [16*CHANNELS-1:0]  v_cap
);

  localparam int STEP_DIV = CLOCK_RATE / STEP_RATE;
  localparam int CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  // Full-scale capacitor voltage: 32767 << 16.
  localparam logic [31:0]        CAP_MAX = 32'h7FFF_0000;
  localparam logic signed [15:0] VC_MIN  = 16'sd256;
  localparam logic signed [15:0] VC_MAX  = 16'sd32766;

  // Reject configurations where a sweep cannot visit every channel.
  if (CHANNELS < 1 || CHANNELS > 16 || STEP_DIV < 1 || CHANNELS > STEP_DIV) begin : g_bad_cfg
    $error("astable_555_vco_bank: CHANNELS must be 1..16 and not exceed CLOCK_RATE/STEP_RATE");
  end

  typedef enum logic [1:0] {
    MODE_CHARGE    = 2'd0,
    MODE_DISCHARGE = 2'd1,
    MODE_HOLD      = 2'd2
  } mode_t;

  logic [CNT_W-1:0]        r_step_cnt;
  logic [31:0]             r_cap  [CHANNELS];
  mode_t                   r_mode [CHANNELS];
  logic [16*CHANNELS-1:0]  r_out;
  logic [16*CHANNELS-1:0]  r_vcap;

  logic [CHANNELS-1:0]     w_hit;
  logic [31:0]             w_cap_cur;
  logic [1:0]              w_mode_bits;
  mode_t                   w_mode_cur;
  logic [15:0]             w_vc_raw;
  logic                    w_pin_n;
  logic signed [15:0]      w_vc;
  logic [15:0]             w_vc_u;
  logic [31:0]             w_mul_a;
  logic [15:0]             w_mul_k;
  logic [31:0]             w_delta;
  logic [32:0]             w_sum;
  logic [31:0]             w_cap_next;
  logic [15:0]             w_c;
  mode_t                   w_mode_next;

  assign out   = r_out;
  assign v_cap = r_vcap;

  // One-hot decode of which channel owns the current clock.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_hit[i] = (r_step_cnt == CNT_W'(i));
    end
  end

  // AND-OR mux of the selected channel's state and inputs onto the shared datapath.
  always_comb begin
    w_cap_cur   = 32'd0;
    w_mode_bits = 2'd0;
    w_vc_raw    = 16'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_cap_cur   = w_cap_cur   | (r_cap[i] & {32{w_hit[i]}});
      w_mode_bits = w_mode_bits | (r_mode[i] & {2{w_hit[i]}});
      w_vc_raw    = w_vc_raw    | (v_control[16*i +: 16] & {16{w_hit[i]}});
    end
    w_mode_cur = mode_t'(w_mode_bits);
    w_pin_n    = |(pin_reset_n & w_hit);
  end

  // Clamp the control voltage, run the integration step and pick the next mode.
  always_comb begin
    w_vc        = $signed(w_vc_raw);
    w_mul_a     = 32'd0;
    w_mul_k     = 16'd0;
    w_delta     = 32'd0;
    w_sum       = 33'd0;
    w_cap_next  = w_cap_cur;
    w_mode_next = w_mode_cur;

    // Out-of-range control voltages must not stop the oscillation.
    if ($signed(w_vc_raw) < VC_MIN) begin
      w_vc = VC_MIN;
    end else if ($signed(w_vc_raw) > VC_MAX) begin
      w_vc = VC_MAX;
    end else begin
      w_vc = $signed(w_vc_raw);
    end
    w_vc_u = $unsigned(w_vc);

    // Charge toward VCC through R1+R2; discharge (also while held) through R2.
    if (w_mode_cur == MODE_CHARGE) begin
      w_mul_a = CAP_MAX - w_cap_cur;
      w_mul_k = 16'(K_CHARGE);
    end else begin
      w_mul_a = w_cap_cur;
      w_mul_k = 16'(K_DISCHARGE);
    end
    w_delta = 32'(({16'd0, w_mul_a} * {32'd0, w_mul_k}) >> K_SHIFT);

    if (w_mode_cur == MODE_CHARGE) begin
      w_sum = {1'b0, w_cap_cur} + {1'b0, w_delta};
      if (w_sum > {1'b0, CAP_MAX}) begin
        w_cap_next = CAP_MAX;
      end else begin
        w_cap_next = w_sum[31:0];
      end
    end else begin
      if (w_delta > w_cap_cur) begin
        w_cap_next = 32'd0;
      end else begin
        w_cap_next = w_cap_cur - w_delta;
      end
    end

    // Comparators act on the post-update voltage. Pin reset wins over them.
    w_c = w_cap_next[31:16];
    if (!w_pin_n) begin
      w_mode_next = MODE_HOLD;
    end else begin
      case (w_mode_cur)
        MODE_CHARGE: begin
          if (w_c >= w_vc_u) begin
            w_mode_next = MODE_DISCHARGE;
          end else begin
            w_mode_next = MODE_CHARGE;
          end
        end
        MODE_DISCHARGE: begin
          if (w_c <= (w_vc_u >> 1)) begin
            w_mode_next = MODE_CHARGE;
          end else begin
            w_mode_next = MODE_DISCHARGE;
          end
        end
        MODE_HOLD: begin
          w_mode_next = MODE_CHARGE;
        end
        default: begin
          w_mode_next = MODE_CHARGE;
        end
      endcase
    end
  end

  // Step counter selecting the channel updated this clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_step_cnt <= '0;
    end else if (r_step_cnt == CNT_W'(STEP_DIV - 1)) begin
      r_step_cnt <= '0;
    end else begin
      r_step_cnt <= r_step_cnt + CNT_W'(1);
    end
  end

  // Per-channel capacitor, mode and debug voltage, written only on the owning clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_cap[i]  <= 32'd0;
        r_mode[i] <= MODE_CHARGE;
      end
      r_vcap <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (w_hit[i]) begin
          r_cap[i]              <= w_cap_next;
          r_mode[i]             <= w_mode_next;
          r_vcap[16*i +: 16]    <= w_cap_next[31:16];
        end
      end
    end
  end

  // Square outputs sampled from the modes on each audio strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out <= '0;
    end else if (audio_clk_en) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_out[16*i +: 16] <= (r_mode[i] == MODE_CHARGE) ? 16'(OUT_HIGH) : 16'd0;
      end
    end
  end

endmodule
